// File: rtl/inv_butterfly_pipe.sv
// Inverse radix-2 butterfly: (s, d) -> a = (s+d)/2, b = (s-d)/2, saturated to OUT_W,
// over a two-stage valid/ready pipe with a frame beat counter. INV_BFLY_PARITY_CHK_EN builds the p[0] parity check.

module inv_bfly_sat #(
  parameter int P_W   = 4,
  parameter int OUT_W = 2
) (
  input  logic signed [P_W-1:0]   v_i,
  output logic signed [OUT_W-1:0] r_o,
  output logic                    sat_o
);
  localparam logic signed [P_W-1:0] MAX_V = P_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [P_W-1:0] MIN_V = P_W'(-(1 << (OUT_W-1)));

  logic signed [P_W-1:0] sh;

  always_comb begin
    sh    = v_i >>> 1;
    r_o   = sh[OUT_W-1:0];
    sat_o = 1'b0;
    if (sh > MAX_V) begin
      r_o   = MAX_V[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (sh < MIN_V) begin
      r_o   = MIN_V[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

module inv_butterfly_pipe #(
  parameter int IN_W      = 3,
  parameter int OUT_W     = IN_W - 1,
  parameter int FRAME_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [IN_W-1:0]       s_in,
  input  logic signed [IN_W-1:0]       d_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_W-1:0]      a_out,
  output logic signed [OUT_W-1:0]      b_out,
  output logic [$clog2(FRAME_LEN)-1:0] out_idx,
  output logic                         out_last,
  output logic                         sat_out,
  output logic                         err_out
);
  localparam int P_W   = IN_W + 1;
  localparam int IDX_W = $clog2(FRAME_LEN);

  logic [2:1]            vld_q;
  logic [1:0][P_W-1:0]   pq_q;   // [0] = p = s+d, [1] = q = s-d
  logic [1:0][OUT_W-1:0] ab_d;
  logic [1:0][OUT_W-1:0] ab_q;
  logic [1:0]            sat_d;
  logic                  sat_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  adv2;
  logic signed [P_W-1:0] s_x, d_x;

  assign s_x      = {s_in[IN_W-1], s_in};
  assign d_x      = {d_in[IN_W-1], d_in};
  assign adv2     = !vld_q[2] || out_ready;
  assign in_ready = !vld_q[1] || adv2;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    inv_bfly_sat #(.P_W(P_W), .OUT_W(OUT_W)) u_sat (
      .v_i   (pq_q[g]),
      .r_o   (ab_d[g]),
      .sat_o (sat_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      pq_q  <= '0;
      ab_q  <= '0;
      sat_q <= 1'b0;
      idx_q <= '0;
    end else begin
      if (in_ready) vld_q[1] <= in_valid;
      if (in_ready && in_valid) begin
        pq_q[0] <= s_x + d_x;
        pq_q[1] <= s_x - d_x;
      end
      if (adv2) vld_q[2] <= vld_q[1];
      if (adv2 && vld_q[1]) begin
        ab_q  <= ab_d;
        sat_q <= |sat_d;
      end
      // FRAME_LEN is a power of two, so natural overflow gives the wrap.
      if (vld_q[2] && out_ready) idx_q <= idx_q + IDX_W'(1);
    end
  end

`ifdef INV_BFLY_PARITY_CHK_EN
  // p and q share parity for any legal pair; odd p flags a corrupt (s, d).
  logic perr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 perr_q <= 1'b0;
    else if (adv2 && vld_q[1])  perr_q <= pq_q[0][0];
  end
  assign err_out = perr_q;
`else
  assign err_out = 1'b0;
`endif

  assign out_valid = vld_q[2];
  assign a_out     = ab_q[0];
  assign b_out     = ab_q[1];
  assign sat_out   = sat_q;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == IDX_W'(FRAME_LEN - 1));
endmodule

// File: tb/tb_inv_butterfly_pipe.sv
// Bench for inv_butterfly_pipe: directed and random (s, d) streams checked against an
// in-order queue model (arrival cycle + 2 latency, two in-flight slots, floor/clamp arithmetic).

module tb_inv_butterfly_pipe;
  localparam int IN_W      = 3;
  localparam int OUT_W     = IN_W - 1;
  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int OMAX      = (1 << (OUT_W-1)) - 1;
  localparam int OMIN      = -(1 << (OUT_W-1));

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [IN_W-1:0]  s_in = '0;
  logic signed [IN_W-1:0]  d_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] a_out;
  logic signed [OUT_W-1:0] b_out;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;
  logic                    sat_out;
  logic                    err_out;

  inv_butterfly_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .out_idx(out_idx), .out_last(out_last),
    .sat_out(sat_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  typedef struct { int s; int d; int t; } item_t;
  item_t q[$];
  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int idx_m = 0;
`ifdef INV_BFLY_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  function automatic int floor_half(int v);
    return (v >= 0) ? v / 2 : -((1 - v) / 2);
  endfunction

  function automatic int clampv(int v);
    return (v > OMAX) ? OMAX : (v < OMIN) ? OMIN : v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, update the model.
  task automatic step(input bit iv, input int s, input int d, input bit ordy, output bit acc);
    bit exp_ir, exp_ov;
    int fa, fb, ea, eb, par;
    @(posedge clk);
    #1;
    cyc++;
    in_valid  = iv;
    s_in      = s[IN_W-1:0];
    d_in      = d[IN_W-1:0];
    out_ready = ordy;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      fa  = floor_half(q[0].s + q[0].d);
      fb  = floor_half(q[0].s - q[0].d);
      ea  = clampv(fa);
      eb  = clampv(fb);
      par = ((q[0].s + q[0].d) % 2 != 0) ? 1 : 0;
      chk("a_out", $signed(a_out), ea);
      chk("b_out", $signed(b_out), eb);
      chk("sat_out", sat_out, (ea != fa || eb != fb) ? 1 : 0);
      chk("err_out", err_out, PAR_EN ? par : 0);
      chk("out_idx", out_idx, idx_m);
      chk("out_last", out_last, (idx_m == FRAME_LEN - 1) ? 1 : 0);
      if (ordy) begin
        void'(q.pop_front());
        idx_m = (idx_m + 1) % FRAME_LEN;
      end
    end
    acc = iv && exp_ir;
    if (acc) q.push_back('{s: s, d: d, t: cyc});
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 0, 0, 1'b1, acc);
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic int rnd_in();
    return int'($urandom_range(7)) - 4;
  endfunction

  initial begin
    bit acc, pend;
    int ps, pd, n;

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_a_out", $signed(a_out), 0);
    chk("rst_sat_err", {sat_out, err_out}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic decode at full throughput
    step(1'b1, 1, 1, 1'b1, acc);
    step(1'b1, -3, -1, 1'b1, acc);
    step(1'b0, 0, 0, 1'b1, acc);
    step(1'b0, 0, 0, 1'b1, acc);
    // Saturation and parity corners
    step(1'b1, 3, 3, 1'b1, acc);
    step(1'b1, 2, 1, 1'b1, acc);
    step(1'b1, -4, -4, 1'b1, acc);
    step(1'b1, -4, 3, 1'b1, acc);
    drain();

    // Backpressure: 8 pairs, out_ready cycling 1,0,0,1, held pair until accepted
    n = 0; pend = 0; ps = 0; pd = 0;
    for (int i = 0; i < 60 && (n < 8 || q.size() > 0); i++) begin
      if (!pend && n < 8) begin ps = rnd_in(); pd = rnd_in(); end
      step(n < 8, ps, pd, (i % 4 == 0) || (i % 4 == 3), acc);
      if (acc) n++;
      pend = !acc && n < 8;
    end
    chk("bp_all_out", q.size(), 0);

    // Reset mid-stream with pairs in flight and a partial frame
    step(1'b1, 1, 1, 1'b0, acc);
    step(1'b1, 1, -1, 1'b0, acc);
    step(1'b1, 2, 2, 1'b0, acc);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_idx", out_idx, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_last", out_last, 0);
    q.delete();
    idx_m = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Framing: 17 continuous beats
    for (int i = 0; i < 17; i++) step(1'b1, rnd_in(), rnd_in(), 1'b1, acc);
    drain();

    // Random valid/ready traffic
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin ps = rnd_in(); pd = rnd_in(); end
      step(pend || ($urandom_range(3) != 0), ps, pd, $urandom_range(2) != 0, acc);
      pend = in_valid && !acc;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
